// File: rtl/eth_arb_pkg.sv
// ----------------------------------------------------------------------------
// eth_arb_pkg
//
// Shared types and constants for the Ethernet TX frame arbiter.
//   arb_state_e : arbiter FSM states (IDLE / XFER / DRAIN)
//   PRIO_RR     : PRIO_MODE value selecting round-robin arbitration
//   PRIO_FIXED  : PRIO_MODE value selecting fixed priority (lowest index wins)
// ----------------------------------------------------------------------------
package eth_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

endpackage

// File: rtl/eth_arb_picker.sv
// ----------------------------------------------------------------------------
// eth_arb_picker
//
// Purely combinational winner selection for the TX frame arbiter.
//
// Parameters
//   CHANNELS  : number of requesters (2..16)
//   PRIO_MODE : PRIO_RR (search starts after last_grant) or
//               PRIO_FIXED (lowest requesting index wins)
// Ports
//   req        in  [CHANNELS]          request vector (one bit per channel)
//   last_grant in  [$clog2(CHANNELS)]  most recently granted channel
//   winner     out [$clog2(CHANNELS)]  selected channel (0 when none)
//   valid      out                     at least one request present
// ----------------------------------------------------------------------------
module eth_arb_picker
    import eth_arb_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int PRIO_MODE = PRIO_RR
) (
    input  logic [CHANNELS-1:0]         req,
    input  logic [$clog2(CHANNELS)-1:0] last_grant,
    output logic [$clog2(CHANNELS)-1:0] winner,
    output logic                        valid
);

    localparam int IW = $clog2(CHANNELS);

    int idx;

    // Both searches walk the candidates in reverse order of preference so the
    // most preferred requester is the last assignment and therefore wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        if (PRIO_MODE == PRIO_FIXED) begin
            for (int i = CHANNELS - 1; i >= 0; i--) begin
                if (req[i]) begin
                    winner = IW'(i);
                    valid  = 1'b1;
                end
            end
        end else begin
            // Offset CHANNELS wraps back onto last_grant itself, so the
            // previous owner is considered only after every other channel.
            for (int s = CHANNELS; s >= 1; s--) begin
                idx = (int'(last_grant) + s) % CHANNELS;
                if (req[idx]) begin
                    winner = IW'(idx);
                    valid  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/eth_tx_frame_arb.sv
// ----------------------------------------------------------------------------
// eth_tx_frame_arb
//
// Merges CHANNELS AXI-stream TX sources into one frame-atomic stream for a
// MAC. A channel is granted for a whole frame; frames longer than
// MAX_FRAME_LEN beats are cut (tlast+tuser forced on the last allowed beat)
// and the remainder of the source frame is drained and discarded.
//
// Optional feature macro: ETH_ARB_STATS_EN
//   When defined, adds the frame_count port and per-channel 32-bit
//   completed-frame counters (wrapping).
//
// Parameters
//   CHANNELS      : number of sources (2..16)
//   DATA_WIDTH    : tdata width per channel and on the output
//   PRIO_MODE     : PRIO_RR (0) round-robin, PRIO_FIXED (1) lowest index wins
//   MAX_FRAME_LEN : beats accepted per frame before truncation
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   s_axis_tdata  in  [CH*DW]     channel i at [i*DW +: DW]
//   s_axis_tvalid/tlast/tuser in  [CH]
//   s_axis_tready out [CH]        only the granted channel may be ready
//   m_axis_tdata/tvalid/tlast/tuser out, m_axis_tready in : merged stream
//   grant_idx     out             currently / most recently granted channel
//   frame_count   out [CH*32]     completed frames per channel (stats only)
//   busy          out             high in XFER or DRAIN
//   state         out             FSM state, for observation
//
// Handshake: a beat moves across an interface on a rising clk edge where
// tvalid and tready are both high. tvalid never depends on tready; the
// arbiter's s_axis_tready depends on m_axis_tready only in XFER, and
// m_axis_tvalid depends only on the granted source's tvalid.
// ----------------------------------------------------------------------------
module eth_tx_frame_arb
    import eth_arb_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int PRIO_MODE     = PRIO_RR,
    parameter int MAX_FRAME_LEN = 1522
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CHANNELS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [CHANNELS-1:0]            s_axis_tvalid,
    input  logic [CHANNELS-1:0]            s_axis_tlast,
    input  logic [CHANNELS-1:0]            s_axis_tuser,
    output logic [CHANNELS-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]          m_axis_tdata,
    output logic                           m_axis_tvalid,
    output logic                           m_axis_tlast,
    output logic                           m_axis_tuser,
    input  logic                           m_axis_tready,
    output logic [$clog2(CHANNELS)-1:0]    grant_idx,
`ifdef ETH_ARB_STATS_EN
    output logic [CHANNELS*32-1:0]         frame_count,
`endif
    output logic                           busy,
    output arb_state_e                     state
);

    localparam int IW = $clog2(CHANNELS);
    localparam int CW = $clog2(MAX_FRAME_LEN + 1);
    // Count value held while the final permitted beat is on the bus.
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_FRAME_LEN - 1);

    logic [IW-1:0]         last_grant;
    logic [IW-1:0]         pick_idx;
    logic                  pick_valid;
    logic [CW-1:0]         beat_cnt;

    logic [DATA_WIDTH-1:0] src_data;
    logic                  src_valid;
    logic                  src_last;
    logic                  src_user;
    logic                  at_limit;
    logic                  out_fire;
    logic                  drain_fire;

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
    eth_arb_picker #(
        .CHANNELS  (CHANNELS),
        .PRIO_MODE (PRIO_MODE)
    ) u_picker (
        .req        (s_axis_tvalid),
        .last_grant (last_grant),
        .winner     (pick_idx),
        .valid      (pick_valid)
    );

    // ------------------------------------------------------------------
    // Granted-source mux
    // ------------------------------------------------------------------
    assign src_data  = s_axis_tdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign src_valid = s_axis_tvalid[grant_idx];
    assign src_last  = s_axis_tlast[grant_idx];
    assign src_user  = s_axis_tuser[grant_idx];

    assign at_limit   = (beat_cnt == LAST_BEAT);
    assign out_fire   = (state == XFER)  && src_valid && m_axis_tready;
    assign drain_fire = (state == DRAIN) && src_valid && src_last;

    // ------------------------------------------------------------------
    // Combinational stream outputs. Data is always steered from the granted
    // channel; only tvalid qualifies it.
    // ------------------------------------------------------------------
    always_comb begin
        s_axis_tready = '0;
        m_axis_tdata  = src_data;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        case (state)
            XFER: begin
                s_axis_tready[grant_idx] = m_axis_tready;
                m_axis_tvalid            = src_valid;
                // A source tlast on the limit beat is a normal frame end,
                // so the forced error flag only applies without it.
                m_axis_tlast             = src_last | at_limit;
                m_axis_tuser             = src_user | (at_limit & ~src_last);
            end
            DRAIN: begin
                s_axis_tready[grant_idx] = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Arbiter FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant_idx  <= '0;
            last_grant <= IW'(CHANNELS - 1);
            beat_cnt   <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // The grant cycle is the single bubble between frames.
                    if (pick_valid) begin
                        grant_idx  <= pick_idx;
                        last_grant <= pick_idx;
                        beat_cnt   <= '0;
                        busy       <= 1'b1;
                        state      <= XFER;
                    end
                end
                XFER: begin
                    if (out_fire) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (src_last) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else if (at_limit) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_fire) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ETH_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Per-channel completed-frame counters; truncated frames count too,
    // since the MAC still sees a terminated frame.
    // ------------------------------------------------------------------
    logic [CHANNELS-1:0][31:0] frame_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (out_fire && m_axis_tlast) begin
            frame_cnt[grant_idx] <= frame_cnt[grant_idx] + 32'd1;
        end
    end

    assign frame_count = frame_cnt;
`endif

endmodule

// File: tb/tb_eth_tx_frame_arb.sv
`timescale 1ns/1ps
module tb_eth_tx_frame_arb;
    import eth_arb_pkg::*;

    localparam int CH   = 4;
    localparam int DW   = 8;
    localparam int MAXL = 8;
    localparam int NI   = 2;   // instance 0: round-robin, instance 1: fixed
    localparam int IW   = 2;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
        logic          u;
    } beat_t;

    typedef struct {
        int            cyc;
        logic [DW-1:0] d;
        logic          l;
        logic          u;
    } obs_t;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [CH*DW-1:0] s_tdata  [NI];
    logic [CH-1:0]    s_tvalid [NI];
    logic [CH-1:0]    s_tlast  [NI];
    logic [CH-1:0]    s_tuser  [NI];
    logic [CH-1:0]    s_tready [NI];
    logic [DW-1:0]    m_tdata  [NI];
    logic             m_tvalid [NI];
    logic             m_tlast  [NI];
    logic             m_tuser  [NI];
    logic             m_tready [NI];
    logic [IW-1:0]    grant    [NI];
    logic             busy     [NI];
    arb_state_e       st       [NI];
`ifdef ETH_ARB_STATS_EN
    logic [CH*32-1:0] fcount   [NI];
`endif

    eth_tx_frame_arb #(
        .CHANNELS(CH), .DATA_WIDTH(DW), .PRIO_MODE(PRIO_RR), .MAX_FRAME_LEN(MAXL)
    ) dut_rr (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata[0]), .s_axis_tvalid(s_tvalid[0]),
        .s_axis_tlast(s_tlast[0]), .s_axis_tuser(s_tuser[0]),
        .s_axis_tready(s_tready[0]),
        .m_axis_tdata(m_tdata[0]), .m_axis_tvalid(m_tvalid[0]),
        .m_axis_tlast(m_tlast[0]), .m_axis_tuser(m_tuser[0]),
        .m_axis_tready(m_tready[0]),
        .grant_idx(grant[0]),
`ifdef ETH_ARB_STATS_EN
        .frame_count(fcount[0]),
`endif
        .busy(busy[0]), .state(st[0])
    );

    eth_tx_frame_arb #(
        .CHANNELS(CH), .DATA_WIDTH(DW), .PRIO_MODE(PRIO_FIXED), .MAX_FRAME_LEN(MAXL)
    ) dut_fixed (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata[1]), .s_axis_tvalid(s_tvalid[1]),
        .s_axis_tlast(s_tlast[1]), .s_axis_tuser(s_tuser[1]),
        .s_axis_tready(s_tready[1]),
        .m_axis_tdata(m_tdata[1]), .m_axis_tvalid(m_tvalid[1]),
        .m_axis_tlast(m_tlast[1]), .m_axis_tuser(m_tuser[1]),
        .m_axis_tready(m_tready[1]),
        .grant_idx(grant[1]),
`ifdef ETH_ARB_STATS_EN
        .frame_count(fcount[1]),
`endif
        .busy(busy[1]), .state(st[1])
    );

    // ------------------------------------------------------------------
    // Bench state
    // ------------------------------------------------------------------
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    bit          toggle_en = 1'b0;
    bit          fire [NI*CH];
    beat_t       src_q [NI*CH][$];
    obs_t        log_q0[$];
    obs_t        log_q1[$];
    logic [DW+1:0] exp_q[$];   // {data, last, user}

    // Model: frame owner (-1 = no owner), previous winner, beats sent in the
    // current frame, whether the rest of a cut frame is being discarded.
    int          owner     [NI];
    int          last_g    [NI];
    int          beats     [NI];
    int          exp_grant [NI];
    bit          drain     [NI];
    int unsigned cnt       [NI][CH];

    task automatic check(input string name, input int inst,
                         input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s inst%0d cyc%0d: got %0h expected %0h", name, inst, cyc, got, exp);
        end
    endtask

    // Preferred channel among requesters, following the arbitration rules.
    function automatic int choose(input int mode, input int last, input logic [CH-1:0] req);
        int w;
        w = -1;
        if (mode == 1) begin
            for (int c = 0; c < CH; c++)
                if (w < 0 && req[c]) w = c;
        end else begin
            for (int s = 1; s <= CH; s++)
                if (w < 0 && req[(last + s) % CH]) w = (last + s) % CH;
        end
        return w;
    endfunction

    task automatic model_step(input int i);
        logic [CH-1:0] v, l, u, er;
        logic          mr, ev, el, eu;
        arb_state_e    es;
        int            o, w;
        v  = s_tvalid[i];
        l  = s_tlast[i];
        u  = s_tuser[i];
        mr = m_tready[i];
        if (rst) begin
            check("rst_busy",   i, 64'(busy[i]),     64'(0));
            check("rst_ready",  i, 64'(s_tready[i]), 64'(0));
            check("rst_mvalid", i, 64'(m_tvalid[i]), 64'(0));
            check("rst_grant",  i, 64'(grant[i]),    64'(0));
`ifdef ETH_ARB_STATS_EN
            check("rst_fcount", i, 64'(fcount[i]),   64'(0));
`endif
            owner[i] = -1; last_g[i] = CH - 1; beats[i] = 0;
            drain[i] = 1'b0; exp_grant[i] = 0;
            for (int c = 0; c < CH; c++) cnt[i][c] = 0;
            return;
        end
        o  = owner[i];
        er = '0; ev = 1'b0; el = 1'b0; eu = 1'b0; es = IDLE;
        if (o >= 0 && !drain[i]) begin
            es    = XFER;
            er[o] = mr;
            ev    = v[o];
            el    = l[o] || (beats[i] == MAXL - 1);
            eu    = u[o] || (beats[i] == MAXL - 1 && !l[o]);
        end else if (o >= 0) begin
            es    = DRAIN;
            er[o] = 1'b1;
        end
        check("busy",   i, 64'(busy[i]),     64'(o >= 0));
        check("grant",  i, 64'(grant[i]),    64'(exp_grant[i]));
        check("sready", i, 64'(s_tready[i]), 64'(er));
        check("mvalid", i, 64'(m_tvalid[i]), 64'(ev));
        check("state",  i, 64'(st[i]),       64'(es));
        if (ev) begin
            check("mdata", i, 64'(m_tdata[i]), 64'(s_tdata[i][o*DW +: DW]));
            check("mlast", i, 64'(m_tlast[i]), 64'(el));
            check("muser", i, 64'(m_tuser[i]), 64'(eu));
        end
`ifdef ETH_ARB_STATS_EN
        for (int c = 0; c < CH; c++)
            check("fcount", i, 64'(fcount[i][c*32 +: 32]), 64'(cnt[i][c]));
`endif
        // Record what the DUT actually delivered, for the literal checks.
        if (m_tvalid[i] && m_tready[i]) begin
            if (i == 0) log_q0.push_back('{cyc, m_tdata[i], m_tlast[i], m_tuser[i]});
            else        log_q1.push_back('{cyc, m_tdata[i], m_tlast[i], m_tuser[i]});
        end
        // Advance the model across the coming edge.
        if (o < 0) begin
            w = choose(i, last_g[i], v);
            if (w >= 0) begin
                owner[i] = w; last_g[i] = w; exp_grant[i] = w;
                beats[i] = 0; drain[i] = 1'b0;
            end
        end else if (!drain[i]) begin
            if (v[o] && mr) begin
                beats[i]++;
                if (el) cnt[i][o]++;
                if (l[o]) owner[i] = -1;
                else if (el) drain[i] = 1'b1;
            end
        end else if (v[o] && l[o]) begin
            owner[i] = -1;
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboard / compare: every negedge
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) model_step(i);
        for (int k = 0; k < NI*CH; k++)
            fire[k] = s_tvalid[k/CH][k%CH] && s_tready[k/CH][k%CH] && !rst;
    end

    // ------------------------------------------------------------------
    // Driver: sources present the head of their queue
    // ------------------------------------------------------------------
    task automatic present(input int k);
        int i, c;
        i = k / CH;
        c = k % CH;
        if (src_q[k].size() > 0) begin
            s_tvalid[i][c]          = 1'b1;
            s_tdata[i][c*DW +: DW]  = src_q[k][0].d;
            s_tlast[i][c]           = src_q[k][0].l;
            s_tuser[i][c]           = src_q[k][0].u;
        end else begin
            s_tvalid[i][c] = 1'b0;
            s_tlast[i][c]  = 1'b0;
            s_tuser[i][c]  = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        #1;
        if (toggle_en) m_tready[0] = ~m_tready[0];
        for (int k = 0; k < NI*CH; k++) begin
            if (fire[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
            present(k);
        end
    end

    task automatic add_frame(input int inst, input int ch, input int len,
                             input int base, input bit user_last);
        beat_t b;
        for (int n = 0; n < len; n++) begin
            b.d = DW'(base + n);
            b.l = (n == len - 1);
            b.u = user_last && (n == len - 1);
            src_q[inst*CH + ch].push_back(b);
        end
    endtask

    task automatic expect_beats(input int base, input int len, input bit last_end,
                                input bit user_end);
        for (int n = 0; n < len; n++)
            exp_q.push_back({DW'(base + n), last_end && (n == len - 1),
                             user_end && (n == len - 1)});
    endtask

    task automatic wait_done(input int inst, input int budget, input string name);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            @(negedge clk);
            #1;
            n++;
            done = !busy[inst];
            for (int c = 0; c < CH; c++)
                if (src_q[inst*CH + c].size() != 0) done = 1'b0;
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL %s_timeout inst%0d: not idle after %0d cycles", name, inst, budget);
        end
    endtask

    task automatic check_log(input int inst, input string name);
        obs_t          o;
        logic [DW+1:0] e;
        int            sz;
        sz = (inst == 0) ? log_q0.size() : log_q1.size();
        check({name, "_len"}, inst, 64'(sz), 64'(exp_q.size()));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (inst == 0 && log_q0.size() > 0) begin
                o = log_q0.pop_front();
                check(name, inst, 64'({o.d, o.l, o.u}), 64'(e));
            end else if (inst == 1 && log_q1.size() > 0) begin
                o = log_q1.pop_front();
                check(name, inst, 64'({o.d, o.l, o.u}), 64'(e));
            end
        end
        if (inst == 0) log_q0.delete();
        else           log_q1.delete();
    endtask

    // ------------------------------------------------------------------
    // Directed tests
    // ------------------------------------------------------------------
    initial begin
        int n;
        for (int i = 0; i < NI; i++) begin
            s_tdata[i] = '0; s_tvalid[i] = '0; s_tlast[i] = '0; s_tuser[i] = '0;
            m_tready[i] = 1'b1;
            owner[i] = -1; last_g[i] = CH - 1; beats[i] = 0;
            drain[i] = 1'b0; exp_grant[i] = 0;
        end
        for (int k = 0; k < NI*CH; k++) fire[k] = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;

        // Round-robin: all four channels, 3-beat frames, channel 0 twice.
        add_frame(0, 0, 3, 'h00, 0);
        add_frame(0, 1, 3, 'h10, 0);
        add_frame(0, 2, 3, 'h20, 0);
        add_frame(0, 3, 3, 'h30, 0);
        add_frame(0, 0, 3, 'h04, 0);
        wait_done(0, 200, "rr");
        if (log_q0.size() == 15)
            for (int f = 1; f < 5; f++)
                check("rr_bubble", 0, 64'(log_q0[3*f].cyc - log_q0[3*f-1].cyc), 64'(2));
        expect_beats('h00, 3, 1, 0);
        expect_beats('h10, 3, 1, 0);
        expect_beats('h20, 3, 1, 0);
        expect_beats('h30, 3, 1, 0);
        expect_beats('h04, 3, 1, 0);
        check_log(0, "rr_order");

        // Fixed priority: channels 1 and 3 both continuously requesting.
        add_frame(1, 1, 2, 'h10, 0);
        add_frame(1, 1, 2, 'h12, 0);
        add_frame(1, 1, 2, 'h14, 0);
        add_frame(1, 3, 2, 'h30, 0);
        add_frame(1, 3, 2, 'h32, 0);
        wait_done(1, 200, "fixed");
        expect_beats('h10, 2, 1, 0);
        expect_beats('h12, 2, 1, 0);
        expect_beats('h14, 2, 1, 0);
        expect_beats('h30, 2, 1, 0);
        expect_beats('h32, 2, 1, 0);
        check_log(1, "fixed_order");

        // Backpressure: m_tready toggles every cycle; channel 3 also waits
        // and carries tuser on its last beat.
        toggle_en = 1'b1;
        add_frame(0, 1, 5, 'h10, 0);
        add_frame(0, 3, 2, 'h38, 1);
        wait_done(0, 200, "bp");
        toggle_en = 1'b0;
        m_tready[0] = 1'b1;
        expect_beats('h10, 5, 1, 0);
        expect_beats('h38, 2, 1, 1);
        check_log(0, "bp_order");

        // Truncation: 12-beat frame on channel 2 is cut after 8 beats.
        add_frame(0, 2, 12, 'h20, 0);
        wait_done(0, 200, "trunc");
        expect_beats('h20, 8, 1, 1);
        check_log(0, "trunc_out");
`ifdef ETH_ARB_STATS_EN
        // Channel 2 completed one frame in the round-robin test plus this one.
        check("trunc_fcount", 0, 64'(fcount[0][2*32 +: 32]), 64'(2));
`endif

        // Boundary: exactly MAXL beats is a normal frame; the following
        // frame on the same channel must not be swallowed by a drain.
        add_frame(0, 3, 8, 'h30, 0);
        add_frame(0, 3, 2, 'h3A, 0);
        wait_done(0, 200, "bound");
        expect_beats('h30, 8, 1, 0);
        expect_beats('h3A, 2, 1, 0);
        check_log(0, "bound_out");

        // Reset mid-frame on channel 1.
        add_frame(0, 1, 6, 'h10, 0);
        n = 0;
        while (log_q0.size() < 3 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("rst_reach_beat3", 0, 64'(log_q0.size() >= 3), 64'(1));
        rst = 1'b1;
        for (int k = 0; k < NI*CH; k++) begin
            src_q[k].delete();
            fire[k] = 1'b0;
            present(k);
        end
        #1;
        check("rst_now_busy",   0, 64'(busy[0]),     64'(0));
        check("rst_now_ready",  0, 64'(s_tready[0]), 64'(0));
        check("rst_now_mvalid", 0, 64'(m_tvalid[0]), 64'(0));
        check("rst_now_grant",  0, 64'(grant[0]),    64'(0));
        expect_beats('h10, 3, 0, 0);
        check_log(0, "rst_partial");
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        // Without the reset, the search would start at 2 and pick channel 3.
        add_frame(0, 0, 2, 'h01, 0);
        add_frame(0, 3, 2, 'h3C, 0);
        wait_done(0, 200, "post_rst");
        expect_beats('h01, 2, 1, 0);
        expect_beats('h3C, 2, 1, 0);
        check_log(0, "post_rst_order");

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #300000;
        fails++;
        $display("FAIL watchdog: simulation did not complete");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

endmodule

// File: doc/eth_tx_frame_arb.md
ETH_TX_FRAME_ARB -- requirements
Module: eth_tx_frame_arb

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of AXI-stream TX sources (2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, tdata width per channel and on the output.
REQ-003 SHALL have parameter PRIO_MODE, default 0, where 0 = round-robin and 1 = fixed priority (lowest index wins).
REQ-004 SHALL have parameter MAX_FRAME_LEN, default 1522, maximum accepted beats per frame before truncation.
REQ-005 SHALL have port clk, input, 1, single clock for all logic.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port s_axis_tdata, input, CHANNELS*DATA_WIDTH, channel i occupying bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have ports s_axis_tvalid, s_axis_tlast and s_axis_tuser, each input, CHANNELS wide, one bit per channel.
REQ-009 SHALL have port s_axis_tready, output, CHANNELS, per-channel ready.
REQ-010 SHALL have ports m_axis_tdata (output, DATA_WIDTH), m_axis_tvalid, m_axis_tlast and m_axis_tuser (outputs, 1 each), and m_axis_tready (input, 1), forming the merged stream to the MAC.
REQ-011 SHALL have port grant_idx, output, $clog2(CHANNELS), index of the currently granted channel.
REQ-012 SHALL have port busy, output, 1, high in XFER or DRAIN.
REQ-013 SHALL have port frame_count, output, CHANNELS*32, per-channel completed-frame counters (present only under ETH_ARB_STATS_EN).

Function
REQ-014 SHALL implement states IDLE, XFER and DRAIN.
REQ-015 In IDLE, with any s_axis_tvalid high, the block SHALL latch the winner into grant_idx and enter XFER on the next edge, giving one bubble cycle per frame; s_axis_tready SHALL be all zero in IDLE.
REQ-016 In round-robin mode, the search SHALL start at (last_grant+1) mod CHANNELS, and last_grant SHALL update only on grant.
REQ-017 In XFER, m_axis_tdata, m_axis_tvalid and m_axis_tuser SHALL pass through combinationally from the granted channel, and s_axis_tready[grant] SHALL equal m_axis_tready; all other readies SHALL be 0.
REQ-018 The grant SHALL never change mid-frame, regardless of requests from other channels.
REQ-019 A beat with m_axis_tvalid, m_axis_tready and tlast all high SHALL return the block to IDLE.
REQ-020 A beat counter (width $clog2(MAX_FRAME_LEN+1)) SHALL count accepted beats and clear on entry to XFER.
REQ-021 When beat MAX_FRAME_LEN is accepted without source tlast, the output SHALL present m_axis_tlast=1 and m_axis_tuser=1 on that beat and then enter DRAIN.
REQ-022 If source tlast coincides with beat MAX_FRAME_LEN, the frame is normal: no truncation, tuser passes through, and the block returns to IDLE.
REQ-023 In DRAIN, s_axis_tready[grant] SHALL be 1 and m_axis_tvalid SHALL be 0; source beats SHALL be discarded until the source tlast is accepted, then the block SHALL return to IDLE.
REQ-024 m_axis_tvalid SHALL be 0 in IDLE and DRAIN.

Reset
REQ-025 On rst, the block SHALL go to IDLE, with grant_idx=0, last_grant=CHANNELS-1 (so channel 0 wins first), beat counter=0, busy=0, all s_axis_tready=0, m_axis_tvalid=0 and frame_count=0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame without emitting tlast; the downstream MAC FIFO is responsible for dropping it.

Configuration
REQ-027 With ETH_ARB_STATS_EN defined, the block SHALL include the frame_count port and registers; each 32-bit counter SHALL increment when its channel's output tlast is accepted (normal or truncated) and wrap from 0xFFFFFFFF to 0.
REQ-028 Without ETH_ARB_STATS_EN, neither the port nor the registers SHALL exist, and all other behaviour SHALL be unchanged.

Structure
REQ-029 Package eth_arb_pkg SHALL hold the arb_state_e enum (IDLE/XFER/DRAIN) and the PRIO_RR/PRIO_FIXED constants.
REQ-030 Sub-module eth_arb_picker SHALL be combinational and compute the winner index and valid from the request vector, last_grant and PRIO_MODE.

Verification
REQ-031 Round-robin: CHANNELS=4, channels 0-3 all holding 3-beat frames -> output order 0,1,2,3,0; one bubble cycle between frames.
REQ-032 Fixed priority: PRIO_MODE=1, channels 1 and 3 valid continuously -> channel 1 wins every arbitration while it is valid.
REQ-033 Backpressure: m_axis_tready toggling 1,0,1,0 during a 5-beat frame -> data order preserved, no beats lost or duplicated, and no other channel's ready asserted.
REQ-034 Truncation: MAX_FRAME_LEN=8, a 12-beat frame on channel 2 -> output of 8 beats with tlast=1 and tuser=1 on beat 8; 4 beats drained; frame_count[2]=1.
REQ-035 Boundary: MAX_FRAME_LEN=8 with an exactly 8-beat frame -> no truncation, tuser=0, and the block returns to IDLE.
REQ-036 Reset: rst pulsed at beat 3 of a frame on channel 1 -> all outputs at reset values within the same cycle, and the next grant goes to channel 0.
